timeset_controller: RTL and testbench

//  Sequences the time-set divider from the hours/minutes set buttons. A press gives one

---
 rtl/timeset_controller_pkg.sv | 16 +
 rtl/timeset_edge_detect.sv | 22 ++
 rtl/timeset_controller.sv | 129 ++++++++++++
 tb/tb_timeset_controller.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/timeset_controller_pkg.sv
// Shared encodings for the time-set controller: FSM states and the latched set target.
package timeset_controller_pkg;

  typedef enum logic [1:0] {
    TsIdle = 2'd0,
    TsSlow = 2'd1,
    TsFast = 2'd2,
    TsLock = 2'd3
  } ts_state_e;

  typedef enum logic {
    TgtHrs = 1'b0,
    TgtMin = 1'b1
  } ts_target_e;

endpackage

// File: rtl/timeset_edge_detect.sv
// 2-bit rising-edge detector. History resets high so a button held through reset
// must be released before it can register a press.
module timeset_edge_detect (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [1:0] i_level,
  output logic [1:0] o_rise
);

  logic [1:0] hist_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= i_level;
    end
  end

  assign o_rise = i_level & ~hist_q;

endmodule

// File: rtl/timeset_controller.sv
// Time-set sequencer: press gives one increment, hold runs the divider slow then fast.
// Optional TIMESET_SEC_CLEAR_EN adds o_sec_clear, pulsed once on entry to LOCK.
module timeset_controller
  import timeset_controller_pkg::*;
#(
  parameter int unsigned SLOW_COUNT = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_set_hours,
  input  logic i_set_minutes,
  input  logic i_timeset_stb,
  output logic o_div_en,
  output logic o_fast_set,
  output logic o_hours_stb,
  output logic o_minutes_stb,
  output logic o_setting
`ifdef TIMESET_SEC_CLEAR_EN
  ,
  output logic o_sec_clear
`endif
);

  localparam logic [7:0] SlowCount = 8'(SLOW_COUNT);

  ts_state_e  state_q, state_d;
  ts_target_e target_q, target_d;
  logic [7:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0] rise;
  logic       tgt_level, other_rise, stb_pulse;
  logic       hours_stb_d, minutes_stb_d, div_en_d, fast_set_d, setting_d;

  // rise[1] = hours, rise[0] = minutes
  timeset_edge_detect u_edge (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_level ({i_set_hours, i_set_minutes}),
    .o_rise  (rise)
  );

  assign tgt_level  = (target_q == TgtHrs) ? i_set_hours : i_set_minutes;
  assign other_rise = (target_q == TgtHrs) ? rise[0] : rise[1];
  assign cnt_inc    = cnt_q + 8'd1;

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    cnt_d     = cnt_q;
    stb_pulse = 1'b0;
    unique case (state_q)
      TsIdle: begin
        if (rise == 2'b11) begin
          state_d = TsLock;
        end else if (rise[1] && !i_set_minutes) begin
          state_d   = TsSlow;
          target_d  = TgtHrs;
          cnt_d     = '0;
          stb_pulse = 1'b1;
        end else if (rise[0] && !i_set_hours) begin
          state_d   = TsSlow;
          target_d  = TgtMin;
          cnt_d     = '0;
          stb_pulse = 1'b1;
        end
      end
      TsSlow, TsFast: begin
        // Release takes priority over a coincident divider strobe.
        if (!tgt_level) begin
          state_d = TsIdle;
        end else if (other_rise) begin
          state_d = TsLock;
        end else if (i_timeset_stb) begin
          stb_pulse = 1'b1;
          if (state_q == TsSlow) begin
            cnt_d = cnt_inc;
            if (cnt_inc == SlowCount) begin
              state_d = TsFast;
            end
          end
        end
      end
      TsLock: begin
        if (!i_set_hours && !i_set_minutes) begin
          state_d = TsIdle;
        end
      end
      default: state_d = TsIdle;
    endcase

    hours_stb_d   = stb_pulse && (target_d == TgtHrs);
    minutes_stb_d = stb_pulse && (target_d == TgtMin);
    div_en_d      = (state_d == TsSlow) || (state_d == TsFast);
    fast_set_d    = (state_d == TsFast);
    setting_d     = (state_d != TsIdle);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q       <= TsIdle;
      target_q      <= TgtHrs;
      cnt_q         <= '0;
      o_div_en      <= 1'b0;
      o_fast_set    <= 1'b0;
      o_hours_stb   <= 1'b0;
      o_minutes_stb <= 1'b0;
      o_setting     <= 1'b0;
    end else begin
      state_q       <= state_d;
      target_q      <= target_d;
      cnt_q         <= cnt_d;
      o_div_en      <= div_en_d;
      o_fast_set    <= fast_set_d;
      o_hours_stb   <= hours_stb_d;
      o_minutes_stb <= minutes_stb_d;
      o_setting     <= setting_d;
    end
  end

`ifdef TIMESET_SEC_CLEAR_EN
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_sec_clear <= 1'b0;
    end else begin
      o_sec_clear <= (state_d == TsLock) && (state_q != TsLock);
    end
  end
`endif

endmodule

// File: tb/tb_timeset_controller.sv
// Directed bench for timeset_controller; expected output vectors are queued per step
// and compared one cycle later.
module tb_timeset_controller;

  logic clk = 1'b0;
  logic i_reset, i_set_hours, i_set_minutes, i_timeset_stb;
  logic o_div_en, o_fast_set, o_hours_stb, o_minutes_stb, o_setting;
  logic sec_clear;

`ifdef TIMESET_SEC_CLEAR_EN
  localparam logic SC_EN = 1'b1;
`else
  localparam logic SC_EN = 1'b0;
  assign sec_clear = 1'b0;
`endif

  // Vector layout: {hours_stb, minutes_stb, div_en, fast_set, setting, sec_clear}
  localparam logic [5:0] O_IDLE = 6'b000000;
  localparam logic [5:0] O_SLOW = 6'b001010;
  localparam logic [5:0] O_FAST = 6'b001110;
  localparam logic [5:0] O_LOCK = 6'b000010;
  localparam logic [5:0] O_LENT = 6'b000011;
  localparam logic [5:0] HS     = 6'b100000;
  localparam logic [5:0] MS     = 6'b010000;

  int         errors = 0;
  int         checks = 0;
  int         step_no = 0;
  string      phase = "init";
  logic [5:0] exp_q[$];

  timeset_controller #(
    .SLOW_COUNT (4)
  ) dut (
    .i_clk         (clk),
    .i_reset       (i_reset),
    .i_set_hours   (i_set_hours),
    .i_set_minutes (i_set_minutes),
    .i_timeset_stb (i_timeset_stb),
    .o_div_en      (o_div_en),
    .o_fast_set    (o_fast_set),
    .o_hours_stb   (o_hours_stb),
    .o_minutes_stb (o_minutes_stb),
    .o_setting     (o_setting)
`ifdef TIMESET_SEC_CLEAR_EN
    ,
    .o_sec_clear   (sec_clear)
`endif
  );

  always #5 clk = ~clk;

  task automatic step(input logic rst, input logic h, input logic m, input logic stb,
                      input logic [5:0] exp);
    logic [5:0] want, got;
    i_reset       = rst;
    i_set_hours   = h;
    i_set_minutes = m;
    i_timeset_stb = stb;
    exp_q.push_back(exp & {5'b11111, SC_EN});
    @(posedge clk);
    #1;
    want = exp_q.pop_front();
    got  = {o_hours_stb, o_minutes_stb, o_div_en, o_fast_set, o_setting, sec_clear};
    step_no++;
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s#%0d observed=%b expected=%b", phase, step_no, got, want);
    end
  endtask

  initial begin
    i_reset = 1'b1; i_set_hours = 1'b0; i_set_minutes = 1'b0; i_timeset_stb = 1'b0;
    #1;

    phase = "reset_held_min";
    step(1, 0, 1, 0, O_IDLE);
    step(1, 0, 1, 0, O_IDLE);
    step(0, 0, 1, 0, O_IDLE);
    step(0, 0, 1, 1, O_IDLE);
    step(0, 0, 1, 0, O_IDLE);
    step(0, 0, 0, 0, O_IDLE);

    phase = "min_press";
    step(0, 0, 1, 0, MS | O_SLOW);
    step(0, 0, 1, 0, O_SLOW);
    step(0, 0, 1, 1, MS | O_SLOW);
    step(0, 0, 1, 0, O_SLOW);

    phase = "release_on_stb";
    step(0, 0, 0, 1, O_IDLE);
    step(0, 0, 0, 0, O_IDLE);

    phase = "hours_hold";
    step(0, 1, 0, 0, HS | O_SLOW);
    step(0, 1, 0, 1, HS | O_SLOW);
    step(0, 1, 0, 0, O_SLOW);
    step(0, 1, 0, 1, HS | O_SLOW);
    step(0, 1, 0, 1, HS | O_SLOW);
    step(0, 1, 0, 1, HS | O_FAST);
    step(0, 1, 0, 0, O_FAST);
    step(0, 1, 0, 1, HS | O_FAST);
    step(0, 1, 0, 1, HS | O_FAST);
    step(0, 0, 0, 1, O_IDLE);
    step(0, 0, 0, 0, O_IDLE);

    phase = "lock_from_slow";
    step(0, 0, 1, 0, MS | O_SLOW);
    step(0, 1, 1, 1, O_LENT);
    step(0, 1, 1, 1, O_LOCK);
    step(0, 0, 1, 0, O_LOCK);
    step(0, 1, 1, 1, O_LOCK);
    step(0, 0, 0, 0, O_IDLE);
    step(0, 0, 0, 1, O_IDLE);

    phase = "both_rise_idle";
    step(0, 1, 1, 0, O_LENT);
    step(0, 1, 1, 1, O_LOCK);
    step(0, 1, 0, 0, O_LOCK);
    step(0, 0, 0, 0, O_IDLE);

    phase = "reset_in_fast";
    step(0, 1, 0, 0, HS | O_SLOW);
    step(0, 1, 0, 1, HS | O_SLOW);
    step(0, 1, 0, 1, HS | O_SLOW);
    step(0, 1, 0, 1, HS | O_SLOW);
    step(0, 1, 0, 1, HS | O_FAST);
    step(1, 1, 0, 1, O_IDLE);
    step(0, 1, 0, 0, O_IDLE);
    step(0, 1, 1, 0, O_IDLE);
    step(0, 0, 0, 0, O_IDLE);
    step(0, 1, 0, 0, HS | O_SLOW);
    step(0, 1, 0, 1, HS | O_SLOW);
    step(0, 1, 0, 1, HS | O_SLOW);
    step(0, 0, 0, 0, O_IDLE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
